// File: rtl/parc_core_rob_fill_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : parc_core_rob_fill_arbiter_pkg
//  Purpose : Shared widths and the packed completion record used by the
//            execute units and the ROB fill / regfile writeback arbiter.
//  Ports   : none (package)
//  Revision: 1.0  initial release
// ============================================================================
package parc_core_rob_fill_arbiter_pkg;

    localparam int C_NUM_REQ = 3;   // ALU, MUL/DIV, MEM
    localparam int C_SLOT_W  = 4;   // ROB slot index width
    localparam int C_PREG_W  = 5;   // physical register address width
    localparam int C_DATA_W  = 32;  // writeback data width

    // One completion as produced by an execute unit.
    typedef struct packed {
        logic                wen;   // 0 for stores / branches
        logic [C_SLOT_W-1:0] slot;
        logic [C_PREG_W-1:0] preg;
        logic [C_DATA_W-1:0] data;
    } rob_cmpl_t;

endpackage : parc_core_rob_fill_arbiter_pkg
`default_nettype wire

// File: rtl/parc_core_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : parc_core_rr_arbiter
//  Purpose : NUM_REQ-wide request vector to one-hot grant. Round-robin by
//            default: the search starts at an internal pointer that moves to
//            one past the last winner. With PARC_ROB_FILL_ARB_FIXED_PRIO_EN
//            defined the pointer is removed and the lowest index always wins.
//  Ports   : clk, rst_n (async, active-low)
//            req_i      request vector
//            gnt_o      one-hot grant (zero when no request)
//            gnt_any_o  any grant this cycle
//            gnt_idx_o  binary index of the granted requester
//  Macro   : PARC_ROB_FILL_ARB_FIXED_PRIO_EN
//  Revision: 1.0  initial release
// ============================================================================
module parc_core_rr_arbiter
    import parc_core_rob_fill_arbiter_pkg::*;
#(
    parameter int NUM_REQ = C_NUM_REQ
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic                       gnt_any_o,
    output logic [$clog2(NUM_REQ)-1:0] gnt_idx_o
);

    localparam int             IDX_W = $clog2(NUM_REQ);
    localparam logic [IDX_W:0] C_NUM = (IDX_W+1)'(NUM_REQ);
    localparam logic [IDX_W-1:0] C_LAST = IDX_W'(NUM_REQ - 1);

    logic [IDX_W-1:0] w_start;   // index the priority search begins at
    logic [IDX_W:0]   w_sum;     // one extra bit so the wrap is a single subtract
    logic             w_any;
    logic [IDX_W-1:0] w_idx;

`ifdef PARC_ROB_FILL_ARB_FIXED_PRIO_EN
    // No state in this mode; clock and reset are kept for a uniform interface.
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, clk, rst_n};
    assign w_start     = '0;
`else
    logic [IDX_W-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (w_any) begin
            ptr_d = (w_idx == C_LAST) ? '0 : w_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign w_start = ptr_q;
`endif

    // First requester at or after w_start, wrapping modulo NUM_REQ.
    always_comb begin
        w_sum = '0;
        w_any = 1'b0;
        w_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, w_start} + (IDX_W+1)'(k);
            if (w_sum >= C_NUM) begin
                w_sum = w_sum - C_NUM;
            end
            if (!w_any && req_i[w_sum[IDX_W-1:0]]) begin
                w_any = 1'b1;
                w_idx = w_sum[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        gnt_o = '0;
        if (w_any) begin
            gnt_o[w_idx] = 1'b1;
        end
    end

    assign gnt_any_o = w_any;
    assign gnt_idx_o = w_idx;

endmodule : parc_core_rr_arbiter
`default_nettype wire

// File: rtl/parc_core_rob_fill_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : parc_core_rob_fill_arbiter
//  Purpose : Shares the ROB fill port and the regfile write port among
//            NUM_REQ completion streams. Each requester has a one-entry
//            holding buffer; one buffered completion is granted per cycle
//            and driven through a registered fill/writeback output.
//  Ports   : clk, reset (async, active-low)
//            req_val/req_rdy        per-requester handshake
//            req_wen/slot/preg/data per-requester completion, packed i*W +: W
//            rob_fill_val/slot      ROB fill strobe and slot
//            rf_wen/waddr/wdata     register-file write port
//  Macro   : PARC_ROB_FILL_ARB_FIXED_PRIO_EN selects fixed priority
//            (lowest index wins) instead of round-robin.
//  Revision: 1.0  initial release
// ============================================================================
module parc_core_rob_fill_arbiter
    import parc_core_rob_fill_arbiter_pkg::*;
#(
    parameter int NUM_REQ = C_NUM_REQ,
    parameter int SLOT_W  = C_SLOT_W,
    parameter int PREG_W  = C_PREG_W,
    parameter int DATA_W  = C_DATA_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_val,
    output logic [NUM_REQ-1:0]        req_rdy,
    input  logic [NUM_REQ-1:0]        req_wen,
    input  logic [NUM_REQ*SLOT_W-1:0] req_slot,
    input  logic [NUM_REQ*PREG_W-1:0] req_preg,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic                      rob_fill_val,
    output logic [SLOT_W-1:0]         rob_fill_slot,
    output logic                      rf_wen,
    output logic [PREG_W-1:0]         rf_waddr,
    output logic [DATA_W-1:0]         rf_wdata
);

    localparam int IDX_W = $clog2(NUM_REQ);

    // Holding buffers
    logic [NUM_REQ-1:0] buf_val_q, buf_val_d;
    logic [NUM_REQ-1:0] buf_wen_q, buf_wen_d;
    logic [SLOT_W-1:0]  buf_slot_q [NUM_REQ];
    logic [SLOT_W-1:0]  buf_slot_d [NUM_REQ];
    logic [PREG_W-1:0]  buf_preg_q [NUM_REQ];
    logic [PREG_W-1:0]  buf_preg_d [NUM_REQ];
    logic [DATA_W-1:0]  buf_data_q [NUM_REQ];
    logic [DATA_W-1:0]  buf_data_d [NUM_REQ];

    // Output register
    logic               fill_val_q, fill_val_d;
    logic [SLOT_W-1:0]  fill_slot_q, fill_slot_d;
    logic               rf_wen_q, rf_wen_d;
    logic [PREG_W-1:0]  rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0]  rf_wdata_q, rf_wdata_d;

    logic [NUM_REQ-1:0] w_gnt;
    logic               w_gnt_any;
    logic [IDX_W-1:0]   w_gnt_idx;
    logic [NUM_REQ-1:0] w_load;

    parc_core_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk       (clk),
        .rst_n     (reset),
        .req_i     (buf_val_q),
        .gnt_o     (w_gnt),
        .gnt_any_o (w_gnt_any),
        .gnt_idx_o (w_gnt_idx)
    );

    // Grant comes from buffer state only, so ready never depends on req_val.
    // A buffer being drained this cycle can take a new entry at the same edge,
    // which lets a lone stream sustain one completion per cycle.
    assign req_rdy = ~buf_val_q | w_gnt;
    assign w_load  = req_val & req_rdy;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            buf_val_d[i]  = buf_val_q[i];
            buf_wen_d[i]  = buf_wen_q[i];
            buf_slot_d[i] = buf_slot_q[i];
            buf_preg_d[i] = buf_preg_q[i];
            buf_data_d[i] = buf_data_q[i];
            // A load takes precedence over the drain: granted-and-refilled
            // leaves the buffer valid with the new entry.
            if (w_load[i]) begin
                buf_val_d[i]  = 1'b1;
                buf_wen_d[i]  = req_wen[i];
                buf_slot_d[i] = req_slot[i*SLOT_W +: SLOT_W];
                buf_preg_d[i] = req_preg[i*PREG_W +: PREG_W];
                buf_data_d[i] = req_data[i*DATA_W +: DATA_W];
            end else if (w_gnt[i]) begin
                buf_val_d[i]  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_val_q <= '0;
            buf_wen_q <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                buf_slot_q[i] <= '0;
                buf_preg_q[i] <= '0;
                buf_data_q[i] <= '0;
            end
        end else begin
            buf_val_q <= buf_val_d;
            buf_wen_q <= buf_wen_d;
            for (int i = 0; i < NUM_REQ; i++) begin
                buf_slot_q[i] <= buf_slot_d[i];
                buf_preg_q[i] <= buf_preg_d[i];
                buf_data_q[i] <= buf_data_d[i];
            end
        end
    end

    // Strobes pulse for exactly one cycle per grant; address/data fields hold
    // their last granted values between grants.
    always_comb begin
        fill_val_d  = w_gnt_any;
        rf_wen_d    = w_gnt_any & buf_wen_q[w_gnt_idx];
        fill_slot_d = fill_slot_q;
        rf_waddr_d  = rf_waddr_q;
        rf_wdata_d  = rf_wdata_q;
        if (w_gnt_any) begin
            fill_slot_d = buf_slot_q[w_gnt_idx];
            rf_waddr_d  = buf_preg_q[w_gnt_idx];
            rf_wdata_d  = buf_data_q[w_gnt_idx];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fill_val_q  <= 1'b0;
            fill_slot_q <= '0;
            rf_wen_q    <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
        end else begin
            fill_val_q  <= fill_val_d;
            fill_slot_q <= fill_slot_d;
            rf_wen_q    <= rf_wen_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
        end
    end

    assign rob_fill_val  = fill_val_q;
    assign rob_fill_slot = fill_slot_q;
    assign rf_wen        = rf_wen_q;
    assign rf_waddr      = rf_waddr_q;
    assign rf_wdata      = rf_wdata_q;

endmodule : parc_core_rob_fill_arbiter
`default_nettype wire

// File: tb/tb_parc_core_rob_fill_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : tb_parc_core_rob_fill_arbiter
//  Purpose : Self-checking bench for parc_core_rob_fill_arbiter. Inputs are
//            driven on the falling edge; a reference model of the holding
//            buffers and the selection rule pushes the expected output of the
//            next rising edge into a queue, and a monitor pops and compares
//            just after each rising edge.
//  Revision: 1.0  initial release
// ============================================================================
module tb_parc_core_rob_fill_arbiter;

    localparam int N  = 3;
    localparam int SW = 4;
    localparam int PW = 5;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_val, req_rdy, req_wen;
    logic [N*SW-1:0] req_slot;
    logic [N*PW-1:0] req_preg;
    logic [N*DW-1:0] req_data;
    logic            rob_fill_val;
    logic [SW-1:0]   rob_fill_slot;
    logic            rf_wen;
    logic [PW-1:0]   rf_waddr;
    logic [DW-1:0]   rf_wdata;

    parc_core_rob_fill_arbiter #(
        .NUM_REQ (N), .SLOT_W (SW), .PREG_W (PW), .DATA_W (DW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_val       (req_val),
        .req_rdy       (req_rdy),
        .req_wen       (req_wen),
        .req_slot      (req_slot),
        .req_preg      (req_preg),
        .req_data      (req_data),
        .rob_fill_val  (rob_fill_val),
        .rob_fill_slot (rob_fill_slot),
        .rf_wen        (rf_wen),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            val;
        bit            wen;
        logic [SW-1:0] slot;
        logic [PW-1:0] preg;
        logic [DW-1:0] data;
    } exp_t;

    exp_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: one entry per requester plus a rotating start index.
    bit            m_val  [N];
    bit            m_wen  [N];
    logic [SW-1:0] m_slot [N];
    logic [PW-1:0] m_preg [N];
    logic [DW-1:0] m_data [N];
    int            m_ptr;
    logic [SW-1:0] h_slot;
    logic [PW-1:0] h_preg;
    logic [DW-1:0] h_data;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_val[i] = 1'b0;
        end
        m_ptr  = 0;
        h_slot = '0;
        h_preg = '0;
        h_data = '0;
        exp_q.delete();
    endtask

    // Called on the falling edge with the inputs for the coming rising edge.
    task automatic model_step();
        int           g;
        int           idx;
        logic [N-1:0] exp_rdy;
        exp_t         e;
        g = -1;
        for (int k = 0; k < N; k++) begin
`ifdef PARC_ROB_FILL_ARB_FIXED_PRIO_EN
            idx = k;
`else
            idx = (m_ptr + k) % N;
`endif
            if (g < 0 && m_val[idx]) g = idx;
        end
        for (int i = 0; i < N; i++) begin
            exp_rdy[i] = !m_val[i] || (g == i);
        end
        check("req_rdy", 64'(req_rdy), 64'(exp_rdy));

        e.val = (g >= 0);
        e.wen = 1'b0;
        if (g >= 0) begin
            e.wen  = m_wen[g];
            h_slot = m_slot[g];
            h_preg = m_preg[g];
            h_data = m_data[g];
            m_val[g] = 1'b0;
            m_ptr    = (g + 1) % N;
        end
        e.slot = h_slot;
        e.preg = h_preg;
        e.data = h_data;
        exp_q.push_back(e);

        for (int i = 0; i < N; i++) begin
            if (req_val[i] && exp_rdy[i]) begin
                m_val[i]  = 1'b1;
                m_wen[i]  = req_wen[i];
                m_slot[i] = req_slot[i*SW +: SW];
                m_preg[i] = req_preg[i*PW +: PW];
                m_data[i] = req_data[i*DW +: DW];
            end
        end
    endtask

    task automatic clear_inputs();
        req_val  = '0;
        req_wen  = '0;
        req_slot = '0;
        req_preg = '0;
        req_data = '0;
    endtask

    task automatic set_req(input int i, input bit v, input bit w, input int slot,
                           input int preg, input logic [DW-1:0] data);
        req_val[i]           = v;
        req_wen[i]           = w;
        req_slot[i*SW +: SW] = SW'(slot);
        req_preg[i*PW +: PW] = PW'(preg);
        req_data[i*DW +: DW] = data;
    endtask

    // Evaluate the model for the current inputs and advance to the next falling edge.
    task automatic cyc();
        if (reset) model_step();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        clear_inputs();
        repeat (n) cyc();
    endtask

    task automatic all_valid(input int s0, input int s1, input int s2);
        set_req(0, 1'b1, 1'b1, s0, 1, 32'h100 + 32'(s0));
        set_req(1, 1'b1, 1'b1, s1, 2, 32'h200 + 32'(s1));
        set_req(2, 1'b1, 1'b1, s2, 3, 32'h300 + 32'(s2));
        cyc();
    endtask

    // Monitor: compares the DUT outputs against the queue after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                check("rst_fill_val", 64'(rob_fill_val), 64'd0);
                check("rst_fill_slot", 64'(rob_fill_slot), 64'd0);
                check("rst_rf_wen", 64'(rf_wen), 64'd0);
                check("rst_rf_waddr", 64'(rf_waddr), 64'd0);
                check("rst_rf_wdata", 64'(rf_wdata), 64'd0);
                check("rst_req_rdy", 64'(req_rdy), 64'h7);
            end else if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL scoreboard: got output with no expectation queued at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                check("rob_fill_val", 64'(rob_fill_val), 64'(e.val));
                check("rf_wen", 64'(rf_wen), 64'(e.wen));
                check("rob_fill_slot", 64'(rob_fill_slot), 64'(e.slot));
                check("rf_waddr", 64'(rf_waddr), 64'(e.preg));
                check("rf_wdata", 64'(rf_wdata), 64'(e.data));
            end
        end
    end

    initial begin
        reset = 1'b0;
        clear_inputs();
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Contention right after reset: start index 0, then 1, 2.
        all_valid(3, 4, 5);
        idle(4);
        // Pointer wrapped after index 2, so index 0 leads again.
        all_valid(3, 4, 5);
        idle(4);

        // Single stream on requester 1, back to back.
        for (int s = 0; s < 6; s++) begin
            clear_inputs();
            set_req(1, 1'b1, 1'b1, s, 7, 32'(s * 10));
            cyc();
        end
        idle(4);

        // Requesters 0 and 2 continuously valid.
        for (int c = 0; c < 10; c++) begin
            clear_inputs();
            set_req(0, 1'b1, 1'b1, c, 10, $urandom);
            set_req(2, 1'b1, 1'b1, 15 - c, 20, $urandom);
            cyc();
        end
        idle(4);

        // Non-writing completion.
        clear_inputs();
        set_req(0, 1'b1, 1'b0, 9, 4, 32'hdead_beef);
        cyc();
        idle(3);

        // Reset in the middle of a drain, right after the first fill appears.
        all_valid(6, 7, 8);
        idle(1);
        reset = 1'b0;
        model_reset();
        clear_inputs();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        idle(5);

        // Random traffic with one reset pulse part-way through.
        for (int c = 0; c < 400; c++) begin
            if (c == 200) begin
                reset = 1'b0;
                model_reset();
                clear_inputs();
                repeat (2) @(negedge clk);
                reset = 1'b1;
            end
            for (int i = 0; i < N; i++) begin
                set_req(i, ($urandom_range(0, 99) < 60), 1'($urandom_range(0, 1)),
                        int'($urandom_range(0, 15)), int'($urandom_range(0, 31)), $urandom);
            end
            cyc();
        end
        idle(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_parc_core_rob_fill_arbiter
`default_nettype wire

// File: doc/parc_core_rob_fill_arbiter.md
Name: parc_core_rob_fill_arbiter

Overview:
- Shares the single ROB fill port and the single register-file write port among NUM_REQ functional-unit completion streams (ALU, MUL/DIV, MEM).
- Each requester has a one-entry holding buffer. A round-robin arbiter picks one buffered completion per cycle and drives a registered fill/writeback output to the reorder buffer and the physical register file.
- Sits between the execute units and the ROB/regfile writeback.

Parameters:
- NUM_REQ, 3, number of completion requesters (2..8)
- SLOT_W, 4, ROB slot index width
- PREG_W, 5, physical register address width
- DATA_W, 32, writeback data width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_val  in  NUM_REQ  completion valid, one bit per requester
- req_rdy  out  NUM_REQ  holding buffer can accept this cycle
- req_wen  in  NUM_REQ  completion writes the register file (0 for stores/branches)
- req_slot  in  NUM_REQ*SLOT_W  ROB slot of each completion, requester i in bits [i*SLOT_W +: SLOT_W]
- req_preg  in  NUM_REQ*PREG_W  destination physical register, packed the same way
- req_data  in  NUM_REQ*DATA_W  result data, packed the same way
- rob_fill_val  out  1  ROB fill strobe
- rob_fill_slot  out  SLOT_W  slot to mark not-pending
- rf_wen  out  1  register-file write enable
- rf_waddr  out  PREG_W  register-file write address
- rf_wdata  out  DATA_W  register-file write data

Behaviour:
- Reset (reset=0, asynchronous):
  - all buffer valid bits 0, round-robin pointer 0
  - rob_fill_val=0, rob_fill_slot=0, rf_wen=0, rf_waddr=0, rf_wdata=0
  - req_rdy = all ones while in reset.
  - Reset asserted mid-operation discards buffered completions and any output in flight.
- Holding buffer i: stores {wen, slot, preg, data}.
  - req_rdy[i] = !buf_val[i] || grant[i]. grant depends only on buffer state, so there is no combinational path from req_val to req_rdy.
  - Transfer occurs when req_val[i] && req_rdy[i]; the buffer loads at that clock edge.
  - If granted and refilled in the same cycle, the new entry replaces the old one: buf_val stays 1.
- Arbitration, combinational, each cycle over candidates buf_val[NUM_REQ-1:0]:
  - Round-robin: the first valid index at or after ptr, wrapping modulo NUM_REQ.
  - At most one grant per cycle. With no candidate, no grant and ptr is unchanged.
  - On grant g, ptr <= (g+1) mod NUM_REQ, wrapping to 0 when g = NUM_REQ-1.
- Output register, loaded every cycle:
  - rob_fill_val <= any grant
  - rf_wen <= any grant && buf_wen[g]
  - rob_fill_slot, rf_waddr, rf_wdata <= buffer g fields when granted, otherwise hold their previous values.
  - No backpressure from the ROB/regfile; the output is a single-cycle pulse.
- Latency: request accepted at edge N, granted during cycle N+1, rob_fill_val high during cycle N+2. Minimum latency is 2 cycles.
- Throughput: 1 fill per cycle total. A single requester streaming alone sustains 1 per cycle through the grant-bypassed req_rdy.
- Fairness: a buffered completion is granted within NUM_REQ cycles under round-robin.
- Simultaneous events: all requesters valid with empty buffers all load in the same cycle, then drain in ptr order over NUM_REQ cycles. During the drain, req_rdy[i] is high only in the cycle in which i is granted.
- Illegal input: req_val with X fields is not checked. Duplicate slots across requesters are the producer's responsibility.

Optional Feature:
- Macro PARC_ROB_FILL_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins. ptr logic is removed and the starvation bound no longer holds.
- Undefined (default): round-robin as specified above.
- Latency, handshake and reset behaviour are identical in both builds.

Decomposition:
- Shared package: SLOT_W, PREG_W and DATA_W defaults, plus a packed completion typedef {wen, slot, preg, data} reused by the execute units.
- One natural sub-module, parc_core_rr_arbiter: NUM_REQ-wide request vector to one-hot grant, with an internal pointer and a fixed-priority mode under the macro. It is also reusable by issue logic.

Test Plan:
- Reset: hold reset=0 for 3 cycles, then release → all outputs 0, req_rdy=3'b111, and the first grant after release goes to index 0 when all are valid.
- Single stream: requester 1 sends slots 0..5 back-to-back (wen=1, preg=7, data=slot*10) → rob_fill_val high for 6 consecutive cycles starting 2 cycles after the first accept; rob_fill_slot 0..5, rf_wdata 0,10,...,50.
- Contention: all 3 valid in one cycle with slots 3/4/5 and ptr=0 → fills in order slots 3,4,5 on consecutive cycles. The next simultaneous burst starts at index 0 again, because ptr wrapped after index 2.
- Round-robin fairness: requesters 0 and 2 continuously valid → grants alternate 0,2,0,2 and neither waits more than 2 cycles. With PARC_ROB_FILL_ARB_FIXED_PRIO_EN defined → requester 0 always wins and requester 2 is starved.
- Non-writing completion: req_wen=0, slot 9 → rob_fill_val=1 with rob_fill_slot=9, and rf_wen=0.
- Reset mid-drain: 3 entries buffered, assert reset after the first fill → no further rob_fill_val, and buffers are empty after release.
